// File: rtl/spi_crypto_slave_if.sv
// rtl/spi_crypto_slave_if.sv - serial link and AES-core handshake bundle for spi_crypto_slave
interface spi_crypto_slave_if #(
  parameter int nk = 8,
  parameter int nb = 4
);
  localparam int KEY_W = 32 * nk;
  localparam int MSG_W = 32 * nb;

  logic             cs;
  logic             Mosi;
  logic             Miso;
  logic             data_done;
  logic [MSG_W-1:0] core_msg;
  logic [KEY_W-1:0] core_key;
  logic             core_start;
  logic [MSG_W-1:0] core_result;
  logic             core_valid;
  logic             parity_err;

  modport slave (
    input  cs, Mosi, core_result, core_valid,
    output Miso, data_done, core_msg, core_key, core_start, parity_err
  );

  modport master (
    output cs, Mosi, core_result, core_valid,
    input  Miso, data_done, core_msg, core_key, core_start, parity_err
  );
endinterface

// File: rtl/spi_crypto_slave.sv
// rtl/spi_crypto_slave.sv - serial {message,key} receiver / result transmitter around an AES core
// Optional trailing even-parity bit on the received frame: define SPI_PARITY_EN.
module spi_crypto_slave #(
  parameter int nk = 8,
  parameter int nb = 4
) (
  input  logic              in_clk,
  input  logic              rst,
  spi_crypto_slave_if.slave bus
);
  localparam int KEY_W  = 32 * nk;
  localparam int MSG_W  = 32 * nb;
  localparam int DATA_W = MSG_W + KEY_W;
`ifdef SPI_PARITY_EN
  localparam int RX_BITS  = DATA_W + 1;
  localparam int RX_SR_W  = DATA_W;
`else
  localparam int RX_BITS  = DATA_W;
  localparam int RX_SR_W  = DATA_W - 1;
`endif
  localparam int CNT_W = $clog2(RX_BITS + 1);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_BITS - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(MSG_W - 1);

  typedef enum logic [2:0] {IDLE, RECV, START, WAIT, SEND} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [RX_SR_W-1:0] rx_sr;
  logic [MSG_W-1:0]   tx_sr;
  logic [MSG_W-1:0]   msg_q;
  logic [KEY_W-1:0]   key_q;
  logic               miso_q;
  logic               done_q;
  logic               start_q;
  logic               rx_last;
  logic [DATA_W-1:0]  rx_word;
  logic               frame_ok;

  assign rx_last = (cnt == RX_LAST);

`ifdef SPI_PARITY_EN
  logic par_acc;
  logic perr_q;
  // The last bit is the parity bit itself, so the data word is already fully shifted in.
  assign rx_word        = rx_sr;
  assign frame_ok       = ~(par_acc ^ bus.Mosi);
  assign bus.parity_err = perr_q;
`else
  assign rx_word        = {rx_sr, bus.Mosi};
  assign frame_ok       = 1'b1;
  assign bus.parity_err = 1'b0;
`endif

  assign bus.Miso       = miso_q;
  assign bus.data_done  = done_q;
  assign bus.core_msg   = msg_q;
  assign bus.core_key   = key_q;
  assign bus.core_start = start_q;

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!bus.cs) state_next = RECV;
      RECV: begin
        if (bus.cs)       state_next = IDLE;
        else if (rx_last) state_next = frame_ok ? START : IDLE;
      end
      START: state_next = WAIT;
      WAIT:  if (bus.core_valid) state_next = SEND;
      SEND:  if (cnt == TX_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      msg_q   <= '0;
      key_q   <= '0;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
`ifdef SPI_PARITY_EN
      par_acc <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.cs) begin
            rx_sr <= {{(RX_SR_W-1){1'b0}}, bus.Mosi};
            cnt   <= CNT_W'(1);
`ifdef SPI_PARITY_EN
            par_acc <= bus.Mosi;
`endif
          end
        end
        RECV: begin
          if (bus.cs) begin
            cnt <= '0;
          end else if (rx_last) begin
            cnt <= '0;
            if (frame_ok) begin
              msg_q   <= rx_word[DATA_W-1 -: MSG_W];
              key_q   <= rx_word[KEY_W-1:0];
              start_q <= 1'b1;
            end
`ifdef SPI_PARITY_EN
            if (!frame_ok) perr_q <= 1'b1;
`endif
          end else begin
            rx_sr <= {rx_sr[RX_SR_W-2:0], bus.Mosi};
            cnt   <= cnt + CNT_W'(1);
`ifdef SPI_PARITY_EN
            par_acc <= par_acc ^ bus.Mosi;
`endif
          end
        end
        WAIT: begin
          if (bus.core_valid) begin
            tx_sr  <= bus.core_result;
            miso_q <= bus.core_result[MSG_W-1];
            done_q <= 1'b1;
            cnt    <= '0;
          end
        end
        SEND: begin
          // Miso already shows the current bit; the edge after bit 0 closes the frame.
          if (cnt == TX_LAST) begin
            miso_q <= 1'b0;
            done_q <= 1'b0;
            cnt    <= '0;
          end else begin
            miso_q <= tx_sr[MSG_W-2];
            tx_sr  <= tx_sr << 1;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
